// File: rtl/handshake_sink.sv
// rtl/handshake_sink.sv - four-phase req/ack receiver presenting words as a valid/ready stream (optional HS_SINK_TIMEOUT_EN)
module handshake_sink #(
    parameter int WIDTH          = 25,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_l,
    input  logic [WIDTH-1:0] input_pins,
    output logic             ack_l,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             timeout_err,
    output logic [15:0]      xfer_cnt
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("handshake_sink: SYNC_STAGES must be >= 2");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("handshake_sink: WIDTH must be >= 1");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("handshake_sink: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   accept;

    assign req_s  = sync_q[SYNC_STAGES-1];
    assign accept = (state == IDLE) && req_s && (!out_valid || out_ready);

    // input_pins is sampled only on accept; the synchroniser delay is the bundling margin
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state     <= IDLE;
            ack_l     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            xfer_cnt  <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], req_l};
            out_valid <= accept || (out_valid && !out_ready);
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_data <= input_pins;
                        ack_l    <= 1'b1;
                        xfer_cnt <= xfer_cnt + 16'd1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (!req_s) begin
                        ack_l <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef HS_SINK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_err_q;

    // Counts HOLD cycles; the error latches on the TIMEOUT_CYCLES-th one and stays until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == HOLD && tmo_cnt != TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_sink.sv
// tb/tb_handshake_sink.sv - directed self-checking bench for handshake_sink
module tb_handshake_sink;

    localparam int WIDTH = 25;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_l;
    logic [WIDTH-1:0] input_pins;
    logic             ack_l;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             timeout_err;
    logic [15:0]      xfer_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    handshake_sink #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_l(req_l),
        .input_pins(input_pins),
        .ack_l(ack_l),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .timeout_err(timeout_err),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input int budget, output int n);
        n = 0;
        while (ack_l !== lvl && n < budget) begin
            tick();
            n++;
        end
        if (ack_l !== lvl) n = -1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; req_l = 1'b1; input_pins = 25'h155AA55; out_ready = 1'b0;
        repeat (3) tick();
        n_cmp++; if (ack_l !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", ack_l); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (xfer_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", xfer_cnt); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
        rst_n = 1'b1;
        tick(); tick();
        n_cmp++; if (ack_l !== 1'b0) begin n_bad++; $display("FAIL reset_rel_early: ack %b want 0 at +2", ack_l); end
        tick();
        exp_cnt = 16'd1;
        n_cmp++; if (ack_l !== 1'b1) begin n_bad++; $display("FAIL reset_rel_ack: ack %b want 1 at +3", ack_l); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 25'h155AA55) begin
            n_bad++; $display("FAIL reset_rel_data: valid %b data %h want 1 155aa55", out_valid, out_data); end
        n_cmp++; if (xfer_cnt !== exp_cnt) begin n_bad++; $display("FAIL reset_rel_cnt: got %0d want %0d", xfer_cnt, exp_cnt); end
        req_l = 1'b0; out_ready = 1'b1;
        wait_ack(1'b0, 20, n);
        n_cmp++; if (n < 0) begin n_bad++; $display("FAIL reset_cleanup: ack stuck %b want 0", ack_l); end
    endtask

    task automatic test_single();
        input_pins = 25'h00ABCDE; out_ready = 1'b1; req_l = 1'b1;
        tick(); tick();
        n_cmp++; if (ack_l !== 1'b0) begin n_bad++; $display("FAIL single_rise_early: ack %b want 0", ack_l); end
        tick();
        exp_cnt++;
        n_cmp++; if (ack_l !== 1'b1 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL single_rise: ack %b valid %b want 1 1", ack_l, out_valid); end
        n_cmp++; if (out_data !== 25'h00ABCDE) begin n_bad++; $display("FAIL single_data: got %h want 0abcde", out_data); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop: valid %b want 0", out_valid); end
        req_l = 1'b0;
        tick(); tick();
        n_cmp++; if (ack_l !== 1'b1) begin n_bad++; $display("FAIL single_fall_early: ack %b want 1", ack_l); end
        tick();
        n_cmp++; if (ack_l !== 1'b0) begin n_bad++; $display("FAIL single_fall: ack %b want 0", ack_l); end
        n_cmp++; if (xfer_cnt !== exp_cnt) begin n_bad++; $display("FAIL single_cnt: got %0d want %0d", xfer_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0; input_pins = 25'h1; req_l = 1'b1;
        wait_ack(1'b1, 20, n);
        n_cmp++; if (n != 3) begin n_bad++; $display("FAIL bp_first_ack: latency %0d want 3", n); end
        exp_cnt++;
        req_l = 1'b0;
        wait_ack(1'b0, 20, n);
        input_pins = 25'h2; req_l = 1'b1;
        repeat (6) tick();
        n_cmp++; if (ack_l !== 1'b0) begin n_bad++; $display("FAIL bp_held_ack: ack %b want 0", ack_l); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 25'h1) begin
            n_bad++; $display("FAIL bp_held_data: valid %b data %h want 1 1", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        exp_cnt++;
        n_cmp++; if (ack_l !== 1'b1 || out_valid !== 1'b1 || out_data !== 25'h2) begin
            n_bad++; $display("FAIL bp_swap: ack %b valid %b data %h want 1 1 2", ack_l, out_valid, out_data); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: valid %b want 0", out_valid); end
        req_l = 1'b0;
        wait_ack(1'b0, 20, n);
        n_cmp++; if (xfer_cnt !== exp_cnt) begin n_bad++; $display("FAIL bp_cnt: got %0d want %0d", xfer_cnt, exp_cnt); end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] got[$];
        int viol = 0;
        int stuck = 0;
        fork
            begin : producer
                int n;
                for (int i = 0; i < 100; i++) begin
                    if (ack_l !== 1'b0) viol++;
                    input_pins = WIDTH'(i); req_l = 1'b1;
                    wait_ack(1'b1, 400, n);
                    if (n < 0) begin stuck++; break; end
                    req_l = 1'b0;
                    wait_ack(1'b0, 400, n);
                    if (n < 0) begin stuck++; break; end
                end
            end
            begin : consumer
                int cyc = 0;
                logic pend;
                logic [WIDTH-1:0] d;
                while (got.size() < 100 && cyc < 40000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    pend = out_valid && out_ready;
                    d = out_data;
                    tick();
                    cyc++;
                    if (pend) got.push_back(d);
                end
            end
        join
        exp_cnt += 16'd100;
        n_cmp++; if (stuck != 0) begin n_bad++; $display("FAIL stream_stuck: %0d hangs want 0", stuck); end
        n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL stream_hs: %0d violations want 0", viol); end
        n_cmp++; if (got.size() != 100) begin n_bad++; $display("FAIL stream_len: got %0d want 100", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== WIDTH'(i)) begin n_bad++; $display("FAIL stream_word%0d: got %0d want %0d", i, got[i], i); end
        end
        n_cmp++; if (xfer_cnt !== exp_cnt) begin n_bad++; $display("FAIL stream_cnt: got %0d want %0d", xfer_cnt, exp_cnt); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        logic want;
`ifdef HS_SINK_TIMEOUT_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        out_ready = 1'b1; input_pins = 25'h7; req_l = 1'b1;
        wait_ack(1'b1, 20, n);
        exp_cnt++;
        repeat (15) tick();
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got %b want 0 at hold 15", timeout_err); end
        tick();
        n_cmp++; if (timeout_err !== want) begin n_bad++; $display("FAIL tmo_set: got %b want %b at hold 16", timeout_err, want); end
        req_l = 1'b0;
        wait_ack(1'b0, 20, n);
        tick();
        n_cmp++; if (timeout_err !== want) begin n_bad++; $display("FAIL tmo_sticky: got %b want %b", timeout_err, want); end
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b0; input_pins = 25'h1F0F0F0; req_l = 1'b1;
        wait_ack(1'b1, 20, n);
        n_cmp++; if (n < 0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_hold: ack %b valid %b want 1 1", ack_l, out_valid); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if (ack_l !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: ack %b valid %b want 0 0", ack_l, out_valid); end
        n_cmp++; if (xfer_cnt !== 16'd0 || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_cnt: cnt %0d tmo %b want 0 0", xfer_cnt, timeout_err); end
        rst_n = 1'b1;
        wait_ack(1'b1, 20, n);
        n_cmp++; if (n != 3) begin n_bad++; $display("FAIL mid_retake: latency %0d want 3", n); end
        n_cmp++; if (xfer_cnt !== 16'd1 || out_data !== 25'h1F0F0F0) begin
            n_bad++; $display("FAIL mid_retake_data: cnt %0d data %h want 1 1f0f0f0", xfer_cnt, out_data); end
        req_l = 1'b0; out_ready = 1'b1;
        wait_ack(1'b0, 20, n);
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
